ga22_sprite_line_feeder: RTL

Per-scanline sprite draw sequencer for the GA22 sprite path. It consumes pre-selected sprite entries for the next line, fetches one 64-bit planar tile row per 16-pixel tile from sprite ROM, and issues paced draw commands (`bits`, `color`, `prio`, `pos`, `we`) into `double_linebuf`. It runs during the line that `double_linebuf` is scanning out the other half, between `line_start` and `line_done`.

---
 rtl/ga22_pkg.sv | 37 +++
 rtl/ga22_sprite_line_feeder.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/ga22_pkg.sv
// GA22 sprite line feeder shared types.
// Entry bundle, sequencer states and plane flip helper.
package ga22_pkg;

  localparam int DRAW_CYCLES_DEFAULT = 8;

  typedef struct packed {
    logic [9:0]  x;
    logic [15:0] code;
    logic [3:0]  row;
    logic [1:0]  width;
    logic        flipx;
    logic [6:0]  color;
    logic        prio;
  } ent_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEPT,
    S_FETCH,
    S_EMIT,
    S_DRAIN
  } state_t;

  function automatic logic [63:0] plane_flip(
    input logic [63:0] d
  );
    logic [63:0] r;
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 16; i++) begin
        r[16*p+i] = d[16*p+15-i];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ga22_sprite_line_feeder.sv
// GA22 per-scanline sprite sequencer: fetches tile rows
// and issues paced draw commands into double_linebuf.
module ga22_sprite_line_feeder
  import ga22_pkg::*;
#(
  parameter int ROM_AW      = 20,
  parameter int DRAW_CYCLES = DRAW_CYCLES_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              line_start,
  output logic              busy,
  output logic              line_done,
  input  logic              ent_valid,
  output logic              ent_ready,
  input  logic              ent_end,
  input  logic [9:0]        ent_x,
  input  logic [15:0]       ent_code,
  input  logic [3:0]        ent_row,
  input  logic [1:0]        ent_width,
  input  logic              ent_flipx,
  input  logic [6:0]        ent_color,
  input  logic              ent_prio,
  output logic              rom_req,
  input  logic              rom_ack,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [63:0]       rom_data,
  output logic [63:0]       bits,
  output logic [6:0]        color,
  output logic              prio,
  output logic [9:0]        pos,
  output logic              we
);

  localparam logic [3:0] PACE = 4'(DRAW_CYCLES - 1);

  state_t      state;
  ent_t        ent;
  ent_t        in_ent;
  logic [2:0]  k;
  logic [2:0]  last;
  logic [63:0] data_q;
  logic [63:0] emit_data;
  logic [3:0]  cnt;
  logic        aborting;
  logic        emit_now;

  function automatic logic [ROM_AW-1:0] tile_addr(
    input ent_t       e,
    input logic [2:0] kk
  );
    logic [2:0]  lk;
    logic [2:0]  t;
    logic [15:0] c;
    lk = 3'((4'd1 << e.width) - 4'd1);
    t  = e.flipx ? lk - kk : kk;
    c  = e.code + {13'd0, t};
    return ROM_AW'({c, e.row});
  endfunction

  always_comb begin
    in_ent = '{
      x:     ent_x,
      code:  ent_code,
      row:   ent_row,
      width: ent_width,
      flipx: ent_flipx,
      color: ent_color,
      prio:  ent_prio
    };
  end

  always_comb begin
    last = 3'((4'd1 << ent.width) - 4'd1);
    emit_now = 1'b0;
    emit_data = data_q;
    if (state == S_FETCH) begin
      emit_data = rom_data;
      emit_now = rom_ack && !aborting
              && cnt == 4'd0;
    end else if (state == S_EMIT) begin
      emit_now = cnt == 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      ent       <= '0;
      k         <= '0;
      data_q    <= '0;
      cnt       <= '0;
      aborting  <= 1'b0;
      busy      <= 1'b0;
      line_done <= 1'b0;
      ent_ready <= 1'b0;
      rom_req   <= 1'b0;
      rom_addr  <= '0;
      bits      <= '0;
      color     <= '0;
      prio      <= 1'b0;
      pos       <= '0;
      we        <= 1'b0;
    end else begin
      we        <= 1'b0;
      line_done <= 1'b0;
      if (cnt != 4'd0) cnt <= cnt - 4'd1;
      if (line_start && state != S_IDLE) begin
        // abort: an in-flight fetch must still complete
        if (rom_req && !rom_ack) begin
          aborting  <= 1'b1;
          ent_ready <= 1'b0;
          state     <= S_FETCH;
        end else begin
          rom_req   <= 1'b0;
          aborting  <= 1'b0;
          ent_ready <= 1'b1;
          state     <= S_ACCEPT;
        end
      end else if (emit_now) begin
        we    <= 1'b1;
        bits  <= ent.flipx ? plane_flip(emit_data)
                           : emit_data;
        pos   <= ent.x + {3'b000, k, 4'b0000};
        color <= ent.color;
        prio  <= ent.prio;
        cnt   <= PACE;
        if (k == last) begin
          rom_req   <= 1'b0;
          ent_ready <= 1'b1;
          state     <= S_ACCEPT;
        end else begin
          k        <= k + 3'd1;
          rom_req  <= 1'b1;
          rom_addr <= tile_addr(ent, k + 3'd1);
          state    <= S_FETCH;
        end
      end else begin
        unique case (state)
          S_IDLE: begin
            if (line_start) begin
              busy      <= 1'b1;
              ent_ready <= 1'b1;
              state     <= S_ACCEPT;
            end
          end
          S_ACCEPT: begin
            if (ent_valid) begin
              ent_ready <= 1'b0;
              if (ent_end) begin
                state <= S_DRAIN;
              end else begin
                ent      <= in_ent;
                k        <= '0;
                rom_req  <= 1'b1;
                rom_addr <= tile_addr(in_ent, 3'd0);
                state    <= S_FETCH;
              end
            end
          end
          S_FETCH: begin
            if (rom_ack) begin
              rom_req <= 1'b0;
              if (aborting) begin
                aborting  <= 1'b0;
                ent_ready <= 1'b1;
                state     <= S_ACCEPT;
              end else begin
                data_q <= rom_data;
                state  <= S_EMIT;
              end
            end
          end
          S_EMIT: begin
          end
          S_DRAIN: begin
            if (cnt == 4'd0) begin
              line_done <= 1'b1;
              busy      <= 1'b0;
              state     <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
